// File: rtl/calc_key_sequencer_if.sv
// Key-event bus between the keypad front-end and the calculator key sequencer.
// The front-end side is the master; the sequencer is the slave.
interface calc_key_sequencer_if #(
    parameter int unsigned DEPTH = 4
);
    logic [7:0]              key_code;
    logic                    key_valid;
    logic [7:0]              calc_in;
    logic                    busy;
    logic [$clog2(DEPTH):0]  count;
    logic                    full;
    logic                    drop;
    logic                    illegal;

    modport master (
        output key_code, key_valid,
        input  calc_in, busy, count, full, drop, illegal
    );

    modport slave (
        input  key_code, key_valid,
        output calc_in, busy, count, full, drop, illegal
    );
endinterface

// File: rtl/calc_key_sequencer.sv
// Buffers legal key events in a FIFO and replays each onto the calculator bus
// for HOLD cycles followed by GAP idle cycles, so repeated keys stay distinct.
module calc_key_sequencer #(
    parameter int unsigned HOLD      = 8,
    parameter int unsigned GAP       = 4,
    parameter int unsigned DEPTH     = 4,
    parameter logic [7:0]  IDLE_CODE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_key_sequencer_if.slave  bus
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned CntW = $clog2((HOLD > GAP ? HOLD : GAP) + 1);
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StDrive, StGap} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q;
    logic [7:0]        code_q;
    logic              drop_q, illegal_q;
    logic              is_legal, full, push, pop;
    logic [7:0]        calc_in;
    logic              busy;

    assign is_legal = ((bus.key_code <= 8'h09) ||
                       (bus.key_code >= 8'h80 && bus.key_code <= 8'h83) ||
                       (bus.key_code == 8'h40) || (bus.key_code == 8'h20)) &&
                      (bus.key_code != IDLE_CODE);
    assign full = (count_q == FullCount);
    // Fullness is judged before the edge, so a same-edge pop never frees a slot.
    assign push = bus.key_valid && is_legal && !full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = StDrive;
                    cnt_d   = CntW'(HOLD - 1);
                end
            end
            StDrive: begin
                if (cnt_q == '0) begin
                    state_d = StGap;
                    cnt_d   = CntW'(GAP - 1);
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = StDrive;
                        cnt_d   = CntW'(HOLD - 1);
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        calc_in = IDLE_CODE;
        busy    = 1'b0;
        if (state_q == StDrive) begin
            calc_in = code_q;
        end
        if (state_q != StIdle) begin
            busy = 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem_q[wptr_q] <= bus.key_code;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            code_q    <= IDLE_CODE;
            drop_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
                code_q <= mem_q[rptr_q];
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
            drop_q    <= bus.key_valid && is_legal && full;
            illegal_q <= bus.key_valid && !is_legal;
        end
    end

    assign bus.calc_in = calc_in;
    assign bus.busy    = busy;
    assign bus.count   = count_q;
    assign bus.full    = full;
    assign bus.drop    = drop_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Scoreboard bench for calc_key_sequencer: a slot-scheduling model predicts when
// each accepted key is popped; a negedge monitor compares every cycle.
module tb_calc_key_sequencer;

    localparam int unsigned HOLD  = 8;
    localparam int unsigned GAP   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  IDLE  = 8'hFF;
    localparam int          INF   = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    calc_key_sequencer_if #(.DEPTH(DEPTH)) bus ();

    calc_key_sequencer #(
        .HOLD(HOLD), .GAP(GAP), .DEPTH(DEPTH), .IDLE_CODE(IDLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp,
                         input int edge_n);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_n, act, exp);
        end
    endtask

    // One record per accepted key: edge accepted, edge popped, edge flushed by reset.
    typedef struct {
        logic [7:0] code;
        int         acc;
        int         pop;
        int         kill;
    } ent_t;

    ent_t hist[$];
    ent_t expq[$];
    int   drop_exp[$];
    int   ill_exp[$];
    int   slot_free = 0;
    bit   mon_en = 1'b0;
    logic [7:0] prev_calc = IDLE;

    function automatic bit legal(input logic [7:0] c);
        return ((c <= 8'h09) || (c >= 8'h80 && c <= 8'h83) || c == 8'h40 || c == 8'h20)
               && c != IDLE;
    endfunction

    function automatic int occ_pre(input int e);
        int n = 0;
        foreach (hist[i]) begin
            if (hist[i].acc < e && hist[i].pop >= e && hist[i].kill >= e) n++;
        end
        return n;
    endfunction

    // Drive one edge's worth of inputs and update the model for that edge.
    task automatic issue(input bit r, input bit v, input logic [7:0] c);
        int   e;
        ent_t en;
        e = cyc + 1;
        rst = r;
        bus.key_valid = v;
        bus.key_code  = c;
        if (!r) begin
            foreach (hist[i]) begin
                if (hist[i].kill == INF) begin
                    hist[i].kill = e;
                    if (hist[i].pop >= e) hist[i].pop = INF;
                end
            end
            while (expq.size() > 0 && expq[$].pop >= e) void'(expq.pop_back());
            slot_free = 0;
        end else if (v) begin
            if (!legal(c)) begin
                ill_exp.push_back(e);
            end else if (occ_pre(e) == DEPTH) begin
                drop_exp.push_back(e);
            end else begin
                en.code = c;
                en.acc  = e;
                en.pop  = (e + 1 > slot_free) ? e + 1 : slot_free;
                en.kill = INF;
                slot_free = en.pop + HOLD + GAP;
                hist.push_back(en);
                expq.push_back(en);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b1, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        int         n;
        logic [7:0] exp_calc;
        bit         exp_busy;
        int         exp_cnt;
        bit         exp_d;
        bit         exp_i;
        ent_t       top;
        if (mon_en) begin
            n = cyc;
            exp_calc = IDLE;
            exp_busy = 1'b0;
            exp_cnt  = 0;
            foreach (hist[i]) begin
                if (n < hist[i].kill) begin
                    if (hist[i].pop <= n && n < hist[i].pop + HOLD) exp_calc = hist[i].code;
                    if (hist[i].pop <= n && n < hist[i].pop + HOLD + GAP) exp_busy = 1'b1;
                    if (hist[i].acc <= n && hist[i].pop > n) exp_cnt++;
                end
            end
            exp_d = (drop_exp.size() > 0 && drop_exp[0] == n);
            if (exp_d) void'(drop_exp.pop_front());
            exp_i = (ill_exp.size() > 0 && ill_exp[0] == n);
            if (exp_i) void'(ill_exp.pop_front());

            check("calc_in", 32'(bus.calc_in), 32'(exp_calc), n);
            check("busy", 32'(bus.busy), 32'(exp_busy), n);
            check("count", 32'(bus.count), 32'(exp_cnt), n);
            check("full", 32'(bus.full), 32'(exp_cnt == DEPTH), n);
            check("drop", 32'(bus.drop), 32'(exp_d), n);
            check("illegal", 32'(bus.illegal), 32'(exp_i), n);

            // A fresh key appearing on the bus retires the oldest scoreboard entry.
            if (bus.calc_in !== IDLE && prev_calc === IDLE) begin
                if (expq.size() == 0) begin
                    check("sb_unexpected_key", 32'(bus.calc_in), 32'(IDLE), n);
                end else begin
                    top = expq.pop_front();
                    check("sb_code", 32'(bus.calc_in), 32'(top.code), n);
                    check("sb_pop_edge", 32'(n), 32'(top.pop), n);
                end
            end
            prev_calc = bus.calc_in;
        end
    end

    logic [7:0] legal_tab [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                   8'h08, 8'h09, 8'h80, 8'h81, 8'h82, 8'h83, 8'h40, 8'h20};

    initial begin
        logic [7:0] c;
        int         r;
        bus.key_valid = 1'b0;
        bus.key_code  = 8'h00;

        // Reset held three edges with key strobes that must be ignored.
        issue(1'b0, 1'b1, 8'h03);
        mon_en = 1'b1;
        issue(1'b0, 1'b0, 8'h00);
        issue(1'b0, 1'b1, 8'h03);
        idle(5);

        issue(1'b1, 1'b1, 8'h03);
        idle(20);

        for (int i = 0; i < 3; i++) issue(1'b1, 1'b1, 8'h05);
        idle(40);

        issue(1'b1, 1'b1, 8'h01);
        idle(3);
        issue(1'b1, 1'b1, 8'h02);
        issue(1'b1, 1'b1, 8'h83);
        issue(1'b1, 1'b1, 8'h40);
        issue(1'b1, 1'b1, 8'h20);
        issue(1'b1, 1'b1, 8'h07);
        idle(70);

        issue(1'b1, 1'b1, 8'h0C);
        issue(1'b1, 1'b1, 8'hC0);
        issue(1'b1, 1'b1, 8'hFF);
        idle(5);

        // 0x82 pops on the edge 0x04 is pushed; reset lands on DRIVE's third cycle.
        issue(1'b1, 1'b1, 8'h82);
        issue(1'b1, 1'b1, 8'h04);
        idle(2);
        issue(1'b0, 1'b0, 8'h00);
        idle(30);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                idle(1);
            end else if (r < 88) begin
                issue(1'b1, 1'b1, legal_tab[$urandom_range(0, 15)]);
            end else if (r < 97) begin
                do c = 8'($urandom); while (legal(c));
                issue(1'b1, 1'b1, c);
            end else begin
                issue(1'b0, ($urandom_range(0, 1) == 1), legal_tab[$urandom_range(0, 15)]);
            end
        end
        idle(80);

        check("sb_leftover_keys", 32'(expq.size()), 32'd0, cyc);
        check("sb_leftover_drop", 32'(drop_exp.size()), 32'd0, cyc);
        check("sb_leftover_illegal", 32'(ill_exp.size()), 32'd0, cyc);
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Key-event scheduler in front of the calculator FSM. It accepts single-cycle key events from the keypad/switch front-end and buffers them in a small FIFO. It then drives each key code onto the calculator's 8-bit `in` bus for a fixed hold window, followed by an idle gap. This guarantees that every key, including repeats of the same key, is seen by the calculator as a distinct level change. Illegal codes and FIFO overflow are flagged instead of being forwarded.

## Interface
- `HOLD`, 8: cycles each key code is held on `calc_in` (≥1).
- `GAP`, 4: cycles `calc_in` sits at `IDLE_CODE` after each key (≥1).
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `IDLE_CODE`, 8'hFF: value driven on `calc_in` when no key is presented.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `key_code` in 8: key code from front-end.
- `key_valid` in 1: one-cycle strobe qualifying `key_code`.
- `calc_in` out 8: drives the calculator FSM `in` bus.
- `busy` out 1: high while in DRIVE or GAP.
- `count` out $clog2(DEPTH)+1: FIFO occupancy.
- `full` out 1: `count == DEPTH`.
- `drop` out 1: one-cycle pulse when a legal key is rejected because the FIFO is full.
- `illegal` out 1: one-cycle pulse when `key_code` is not a legal code.

## Operation
- Legal codes:
  - digits 8'h00–8'h09;
  - operators 8'h80–8'h83 (+ − × ÷);
  - equals 8'h40;
  - clear 8'h20.
- Every other code, and any code equal to `IDLE_CODE`, is illegal.
- Push: on an edge with `rst`=1 and `key_valid`=1:
  - illegal code: `illegal` pulses and nothing is pushed (an illegal code never raises `drop`);
  - legal code with `full`=1 (pre-edge value): `drop` pulses and the code is discarded;
  - legal code otherwise: the code is written at the tail.
- FSM states and transitions:
  - IDLE: `calc_in`=`IDLE_CODE`, `busy`=0. If `count`>0 at an edge, pop the head into the output register and go to DRIVE.
  - DRIVE: `calc_in`=popped code. After `HOLD` cycles go to GAP.
  - GAP: `calc_in`=`IDLE_CODE`. After `GAP` cycles, if `count`>0 pop and go directly to DRIVE; else go to IDLE.
- A single down-counter is reloaded with `HOLD-1` or `GAP-1` on entry to a state. The transition occurs on the edge where the counter reads 0.
- Simultaneous push and pop on one edge: both take effect and `count` is unchanged. A push into a FIFO that is full before the edge is rejected even if a pop happens on the same edge.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `count` is tracked separately to distinguish full from empty.
- Reset (`rst`=0 at any edge, including mid-DRIVE/GAP):
  - state → IDLE;
  - FIFO flushed, `count`=0;
  - `calc_in`=`IDLE_CODE`;
  - `busy`=0, `full`=0, `drop`=0, `illegal`=0.
- `key_valid` is ignored during reset.

## Timing
- All outputs are registered; none depend combinationally on inputs.
- Key accepted at edge E into an empty FIFO with the FSM in IDLE:
  - `count`=1 after E;
  - pop at E+1, where `calc_in`=code, `busy`=1 and `count`=0.
- The code is held for exactly `HOLD` cycles (edges E+1 … E+HOLD), then `IDLE_CODE` for exactly `GAP` cycles.
- Back-to-back keys occupy a period of `HOLD`+`GAP` cycles with no extra IDLE cycle. Defaults give 12 cycles per key.
- `drop` and `illegal` are asserted for the single cycle following the offending edge.

## Test plan
- Reset values: hold `rst`=0 for 3 cycles while pulsing `key_valid` with 8'h03. Required response:
  - `calc_in`=8'hFF, `count`=0, `busy`=0;
  - no pulses;
  - after release, nothing is driven.
- Single key: `key_valid` with 8'h03 at edge E. Required response:
  - `calc_in`=8'h03 at E+1 through E+8;
  - 8'hFF at E+9 through E+12;
  - `busy` falls after E+12.
- Repeated key: push 8'h05 three times on consecutive cycles. Required response:
  - `calc_in` shows 8'h05 three times, each for 8 cycles, separated by 4 cycles of 8'hFF;
  - `count` peaks at 2.
- Overflow: with the FSM in DRIVE, push 5 legal codes back-to-back (DEPTH=4). Required response:
  - `full`=1 after the 4th push;
  - the 5th raises `drop` for one cycle;
  - the four codes appear in push order.
- Illegal codes: push 8'h0C, 8'hC0 and 8'hFF. Required response:
  - `illegal` pulses 3 times;
  - `count` stays 0 and `calc_in` stays 8'hFF.
- Reset mid-operation: push 8'h82 and 8'h04, then assert `rst`=0 at cycle 3 of DRIVE. Required response:
  - `calc_in`=8'hFF and `count`=0 after that edge;
  - 8'h04 is never driven.
